// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Downstream checker for an even clock divider. The divided clock is sampled
// directly in the clk domain. The block measures every period and high time
// in clk cycles, declares lock after LOCK_CNT consecutive good periods, and
// flags loss of the divided clock or any bad period seen while locked.
//
// Observability: dbg_state exposes the measurement FSM (0=IDLE, 1=HIGH, 2=LOW).
module div_clk_monitor #(
   parameter int N        = 6,     // expected division ratio (even, >= 2)
   parameter int CNT_W    = 16,    // width of counters and measurement outputs
   parameter int LOCK_CNT = 4,     // consecutive good periods needed for lock
   parameter int TIMEOUT  = 1024   // edge-free clk cycles before loss is declared
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_in,
   input  logic             clr,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout,
   output logic             err_sticky,
   output logic [1:0]       dbg_state
);

   localparam int OK_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(N);
   localparam logic [CNT_W-1:0] C_HALF   = CNT_W'(N / 2);
   localparam logic [CNT_W-1:0] C_TO     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_TO_M1  = CNT_W'(TIMEOUT - 1);
   localparam logic [OK_W-1:0]  C_LOCK   = OK_W'(LOCK_CNT);
   localparam logic [OK_W-1:0]  C_OK_ONE = OK_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic             r_p;          // previous sample of div_in
   state_t           r_state;
   logic [CNT_W-1:0] r_hcnt;       // cycles spent high in the current period
   logic [CNT_W-1:0] r_lcnt;       // cycles spent low in the current period
   logic [CNT_W-1:0] r_idle_cnt;   // cycles since the last edge, saturating
   logic [OK_W-1:0]  r_ok_cnt;     // consecutive good periods, saturating
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic             r_meas_valid;
   logic             r_locked;
   logic             r_timeout;
   logic             r_err;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic             w_rise;
   logic             w_fall;
   logic             w_quiet;
   logic             w_publish;
   logic             w_to_event;
   logic             w_good;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_period_sat;
   logic [CNT_W-1:0] w_hcnt_inc;
   logic [CNT_W-1:0] w_lcnt_inc;
   logic [OK_W-1:0]  w_ok_inc;

   assign w_rise  = div_in & ~r_p;
   assign w_fall  = ~div_in & r_p;
   assign w_quiet = ~w_rise & ~w_fall;

   // A completed period is published on the rise that closes the low phase.
   assign w_publish = (r_state == S_LOW) & w_rise;

   // Loss is declared on the single cycle the idle counter reaches TIMEOUT;
   // once saturated it stays put, so the event cannot repeat until an edge.
   assign w_to_event = w_quiet & (r_idle_cnt == C_TO_M1);

   // One extra bit keeps the period sum from wrapping before saturation.
   assign w_sum        = {1'b0, r_hcnt} + {1'b0, r_lcnt};
   assign w_period_sat = w_sum[CNT_W] ? C_MAX : w_sum[CNT_W-1:0];
   assign w_good       = (w_sum == {1'b0, C_PERIOD}) && (r_hcnt == C_HALF);

   assign w_hcnt_inc = (r_hcnt == C_MAX) ? C_MAX : r_hcnt + C_ONE;
   assign w_lcnt_inc = (r_lcnt == C_MAX) ? C_MAX : r_lcnt + C_ONE;
   assign w_ok_inc   = (r_ok_cnt == C_LOCK) ? C_LOCK : r_ok_cnt + C_OK_ONE;

   // Previous-sample register for edge detection; cleared so a level that is
   // already high after reset or clear counts as a fresh rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p <= 1'b0;
      end else if (clr) begin
         r_p <= 1'b0;
      end else begin
         r_p <= div_in;
      end
   end

   // Measurement FSM: tracks the high and low phases and counts their length.
   // Whatever phase precedes the first rise after IDLE is never measured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_hcnt  <= '0;
         r_lcnt  <= '0;
      end else if (clr) begin
         r_state <= S_IDLE;
         r_hcnt  <= '0;
         r_lcnt  <= '0;
      end else if (w_to_event) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_HIGH;
                  r_hcnt  <= C_ONE;
                  r_lcnt  <= '0;
               end
            end
            S_HIGH: begin
               if (w_fall) begin
                  r_state <= S_LOW;
                  r_lcnt  <= C_ONE;
               end else begin
                  r_hcnt <= w_hcnt_inc;
               end
            end
            S_LOW: begin
               if (w_rise) begin
                  r_state <= S_HIGH;
                  r_hcnt  <= C_ONE;
                  r_lcnt  <= '0;
               end else begin
                  r_lcnt <= w_lcnt_inc;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Edge-free cycle counter; runs in every state so a dead input is caught.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle_cnt <= '0;
      end else if (clr) begin
         r_idle_cnt <= '0;
      end else if (!w_quiet) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != C_TO) begin
         r_idle_cnt <= r_idle_cnt + C_ONE;
      end
   end

   // Loss-of-clock level: set on the timeout event, cleared by the next rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timeout <= 1'b0;
      end else if (clr) begin
         r_timeout <= 1'b0;
      end else if (w_rise) begin
         r_timeout <= 1'b0;
      end else if (w_to_event) begin
         r_timeout <= 1'b1;
      end
   end

   // Measurement outputs; they hold their last value across a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period     <= '0;
         r_high       <= '0;
         r_meas_valid <= 1'b0;
      end else if (clr) begin
         r_period     <= '0;
         r_high       <= '0;
         r_meas_valid <= 1'b0;
      end else begin
         r_meas_valid <= w_publish;
         if (w_publish) begin
            r_period <= w_period_sat;
            r_high   <= r_hcnt;
         end
      end
   end

   // Good-period streak and lock flag; lock is computed from the next streak
   // value so it rises together with the meas_valid that completes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ok_cnt <= '0;
         r_locked <= 1'b0;
      end else if (clr) begin
         r_ok_cnt <= '0;
         r_locked <= 1'b0;
      end else if (w_to_event) begin
         r_ok_cnt <= '0;
         r_locked <= 1'b0;
      end else if (w_publish) begin
         if (w_good) begin
            r_ok_cnt <= w_ok_inc;
            r_locked <= (w_ok_inc == C_LOCK);
         end else begin
            r_ok_cnt <= '0;
            r_locked <= 1'b0;
         end
      end
   end

   // Sticky error: any bad period or loss of clock observed while locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (clr) begin
         r_err <= 1'b0;
      end else if (r_locked && (w_to_event || (w_publish && !w_good))) begin
         r_err <= 1'b1;
      end
   end

   assign period_o   = r_period;
   assign high_o     = r_high;
   assign meas_valid = r_meas_valid;
   assign locked     = r_locked;
   assign timeout    = r_timeout;
   assign err_sticky = r_err;
   assign dbg_state  = r_state;

endmodule
